// File: rtl/datapath_mc.sv
// Multi-cycle load/store/add/sub datapath. A sequencer steps each instruction
// through register read, ALU, optional memory access and writeback.
module datapath_mc #(
   parameter int unsigned BITS      = 63,
   parameter int unsigned REGS      = 32,
   parameter int unsigned MEM_DEPTH = 32,
   parameter int unsigned IMM_W     = 9
) (
   input  logic             i_clk,
   input  logic             i_reset,
   input  logic             i_start,
   input  logic [2:0]       i_op,
   input  logic [4:0]       i_ra,
   input  logic [4:0]       i_rb,
   input  logic [4:0]       i_rw,
   input  logic [IMM_W-1:0] i_imm,
   output logic             o_busy,
   output logic             o_done,
   output logic [BITS:0]    o_result,
   output logic             o_flag_z,
   output logic             o_flag_v,
   output logic [BITS:0]    o_data_out_a,
   output logic [BITS:0]    o_data_out_b
);

   localparam int unsigned AW = $clog2(MEM_DEPTH);

   localparam logic [2:0] OpAdd  = 3'b000;
   localparam logic [2:0] OpSub  = 3'b001;
   localparam logic [2:0] OpAddi = 3'b010;
   localparam logic [2:0] OpSubi = 3'b011;
   localparam logic [2:0] OpLdur = 3'b100;
   localparam logic [2:0] OpStur = 3'b101;
   localparam logic [2:0] OpAnd  = 3'b110;
   localparam logic [2:0] OpOrr  = 3'b111;

   typedef enum logic [2:0] {StIdle, StRead, StExec, StMem, StWb} state_e;

   state_e           r_state, w_state_next;
   logic [2:0]       r_op;
   logic [4:0]       r_ra, r_rb, r_rw;
   logic [IMM_W-1:0] r_imm;
   logic [BITS:0]    r_a, r_b, r_result;
   logic [AW-1:0]    r_addr;
   logic             r_z, r_v;
   logic [BITS:0]    r_rf  [REGS];
   logic [BITS:0]    r_mem [MEM_DEPTH];

   logic [BITS:0]    w_imm_ext, w_bsel, w_badd, w_sum, w_alu, w_rd_a, w_rd_b;
   logic             w_use_imm, w_sub, w_ovf;

   // Sequencer next state and status outputs.
   always_comb begin
      w_state_next = r_state;
      o_busy       = 1'b0;
      o_done       = 1'b0;
      case (r_state)
         StIdle: if (i_start) w_state_next = StRead;
         StRead: begin
            o_busy       = 1'b1;
            w_state_next = StExec;
         end
         StExec: begin
            o_busy       = 1'b1;
            w_state_next = (r_op == OpLdur || r_op == OpStur) ? StMem : StWb;
         end
         StMem: begin
            o_busy       = 1'b1;
            w_state_next = StWb;
         end
         StWb: begin
            o_done       = 1'b1;
            w_state_next = StIdle;
         end
         default: w_state_next = StIdle;
      endcase
   end

   // Register-file read ports and ALU; subtraction is a + ~b + 1, and the overflow
   // test uses the sign of the adder's actual second input.
   always_comb begin
      w_rd_a    = (32'(r_ra) < REGS - 1) ? r_rf[r_ra] : '0;
      w_rd_b    = (32'(r_rb) < REGS - 1) ? r_rf[r_rb] : '0;
      w_imm_ext = {{(BITS + 1 - IMM_W){r_imm[IMM_W-1]}}, r_imm};
      w_use_imm = (r_op == OpAddi) || (r_op == OpSubi) || (r_op == OpLdur) || (r_op == OpStur);
      w_sub     = (r_op == OpSub) || (r_op == OpSubi);
      w_bsel    = w_use_imm ? w_imm_ext : r_b;
      w_badd    = w_sub ? ~w_bsel : w_bsel;
      w_sum     = r_a + w_badd + {{BITS{1'b0}}, w_sub};
      w_ovf     = (r_a[BITS] == w_badd[BITS]) && (w_sum[BITS] != r_a[BITS]);
      w_alu     = w_sum;
      if (r_op == OpAnd) w_alu = r_a & r_b;
      if (r_op == OpOrr) w_alu = r_a | r_b;
   end

   // Datapath state: instruction latch, operands, result, flags and register file.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_state  <= StIdle;
         r_op     <= '0;
         r_ra     <= '0;
         r_rb     <= '0;
         r_rw     <= '0;
         r_imm    <= '0;
         r_a      <= '0;
         r_b      <= '0;
         r_result <= '0;
         r_addr   <= '0;
         r_z      <= 1'b0;
         r_v      <= 1'b0;
         for (int i = 0; i < REGS; i++) r_rf[i] <= '0;
      end else begin
         r_state <= w_state_next;
         case (r_state)
            StIdle: begin
               if (i_start) begin
                  r_op  <= i_op;
                  r_ra  <= i_ra;
                  r_rb  <= i_rb;
                  r_rw  <= i_rw;
                  r_imm <= i_imm;
               end
            end
            StRead: begin
               r_a <= w_rd_a;
               r_b <= w_rd_b;
            end
            StExec: begin
               r_addr <= w_alu[AW-1:0];
               if (r_op != OpLdur) r_result <= w_alu;
               case (r_op)
                  OpAdd, OpSub, OpAddi, OpSubi: begin
                     r_z <= (w_alu == '0);
                     r_v <= w_ovf;
                  end
                  OpAnd, OpOrr: begin
                     r_z <= (w_alu == '0);
                     r_v <= 1'b0;
                  end
                  default: ;
               endcase
            end
            StMem: begin
               if (r_op == OpLdur) r_result <= r_mem[r_addr];
            end
            StWb: begin
               if (r_op != OpStur && 32'(r_rw) < REGS - 1) r_rf[r_rw] <= r_result;
            end
            default: ;
         endcase
      end
   end

   // Data RAM write port; contents survive reset, but a reset edge blocks a pending store.
   always_ff @(posedge i_clk) begin
      if (!i_reset && r_state == StMem && r_op == OpStur) r_mem[r_addr] <= r_b;
   end

   assign o_result     = r_result;
   assign o_flag_z     = r_z;
   assign o_flag_v     = r_v;
   assign o_data_out_a = r_a;
   assign o_data_out_b = r_b;

endmodule
